// File: rtl/dcache_responder_pkg.sv
// Shared types and address/word helpers for the direct-mapped L1 data cache.
package dcache_types;

    localparam int DCACHE_LINE_W   = 256;
    localparam int DCACHE_OFFSET_W = 5;
    localparam int DCACHE_WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } dcache_state_t;

    function automatic logic [2:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

    function automatic logic [7:0] word_bit_base(input logic [2:0] word_sel);
        return {word_sel, 5'b0};
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dcache_responder_array.sv
// Flop-based valid/dirty/tag/line storage with combinational read and synchronous update.
module dcache_array
    import dcache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [S_INDEX-1:0]       index,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [DCACHE_LINE_W-1:0] rd_line,
    input  logic                     word_we,
    input  logic [2:0]               word_sel,
    input  logic [3:0]               word_be,
    input  logic [31:0]              word_data,
    input  logic                     fill_we,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic [DCACHE_LINE_W-1:0] fill_line
);

    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]          valid_q, valid_d;
    logic [SETS-1:0]          dirty_q, dirty_d;
    logic [TAG_W-1:0]         tag_q  [SETS];
    logic [TAG_W-1:0]         tag_d  [SETS];
    logic [DCACHE_LINE_W-1:0] line_q [SETS];
    logic [DCACHE_LINE_W-1:0] line_d [SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        line_d  = line_q;
        if (fill_we) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
            tag_d[index]   = fill_tag;
            line_d[index]  = fill_line;
        end else if (word_we) begin
            line_d[index][word_bit_base(word_sel) +: DCACHE_WORD_W] =
                merge_word(line_q[index][word_bit_base(word_sel) +: DCACHE_WORD_W],
                           word_data, word_be);
            // An all-lanes-off store leaves the line clean so it is not written back.
            if (|word_be) begin
                dirty_d[index] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = line_q[index];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate L1 data cache answering the d_* port.
// Optional perf counters are built when DCACHE_PERF_EN is defined.
module dcache_responder
    import dcache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     d_read,
    input  logic                     d_write,
    input  logic [3:0]               mem_byte_enable,
    input  logic [31:0]              d_addr,
    input  logic [31:0]              d_wdata,
    output logic                     d_resp,
    output logic [31:0]              d_rdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [31:0]              pmem_addr,
    output logic [DCACHE_LINE_W-1:0] pmem_wdata,
    input  logic [DCACHE_LINE_W-1:0] pmem_rdata,
    input  logic                     pmem_resp,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int TAG_W = 32 - DCACHE_OFFSET_W - S_INDEX;

    dcache_state_t state_q, state_d;

    logic [S_INDEX-1:0]       req_index;
    logic [TAG_W-1:0]         req_tag;
    logic [2:0]               req_word;
    logic                     req;
    logic                     tag_match;
    logic                     set_valid;
    logic                     set_dirty;
    logic [TAG_W-1:0]         set_tag;
    logic [DCACHE_LINE_W-1:0] set_line;
    logic                     word_we;
    logic                     fill_we;
    logic                     addr_unused;

    assign req_index   = d_addr[DCACHE_OFFSET_W +: S_INDEX];
    assign req_tag     = d_addr[31 -: TAG_W];
    assign req_word    = addr_word(d_addr);
    assign req         = d_read | d_write;
    assign tag_match   = set_valid && (set_tag == req_tag);
    assign addr_unused = ^d_addr[1:0];

    dcache_array #(
        .S_INDEX (S_INDEX),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (req_index),
        .rd_valid  (set_valid),
        .rd_dirty  (set_dirty),
        .rd_tag    (set_tag),
        .rd_line   (set_line),
        .word_we   (word_we),
        .word_sel  (req_word),
        .word_be   (mem_byte_enable),
        .word_data (d_wdata),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_line (pmem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !tag_match) begin
                    state_d = (set_valid && set_dirty) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The request is never latched: after a fill the IDLE lookup replays it and hits.
    always_comb begin
        d_resp     = 1'b0;
        d_rdata    = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        word_we    = 1'b0;
        fill_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && tag_match) begin
                    d_resp = 1'b1;
                    if (d_write) begin
                        word_we = 1'b1;
                    end else begin
                        d_rdata = set_line[word_bit_base(req_word) +: DCACHE_WORD_W];
                    end
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                pmem_addr  = {set_tag, req_index, 5'b0};
                pmem_wdata = set_line;
            end
            FILL: begin
                pmem_read = 1'b1;
                pmem_addr = {req_tag, req_index, 5'b0};
                fill_we   = pmem_resp;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        miss_event;

    assign miss_event = (state_q == IDLE) && req && !tag_match;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (d_resp && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_event && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed vector table, reset corner cases,
// then random traffic checked against a per-set cache model over a sparse backing memory.
module tb_dcache_responder;

   localparam int S_INDEX = 3;
   localparam int SETS    = 1 << S_INDEX;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [3:0]   mem_byte_enable = '0;
   logic [31:0]  d_addr = '0;
   logic [31:0]  d_wdata = '0;
   logic         d_resp;
   logic [31:0]  d_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_addr;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   dcache_responder #(.S_INDEX(S_INDEX)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .d_read          (d_read),
      .d_write         (d_write),
      .mem_byte_enable (mem_byte_enable),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_resp          (d_resp),
      .d_rdata         (d_rdata),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_addr       (pmem_addr),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference model: backing memory by line number plus what each set holds
   logic [255:0] backing [int];
   bit           mdl_valid [SETS];
   bit           mdl_dirty [SETS];
   int           mdl_tag   [SETS];
   logic [255:0] mdl_line  [SETS];
   int           mdl_hits   = 0;
   int           mdl_misses = 0;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      int          lat;
      bit          chk_data;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs [10];

   // Compares one observed value against the bench's own expectation
   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Line contents as memory holds them, with a recognisable default pattern
   function automatic logic [255:0] mem_line(input int lineno);
      logic [255:0] l;
      if (backing.exists(lineno)) begin
         return backing[lineno];
      end
      for (int w = 0; w < 8; w++) begin
         l[w*32 +: 32] = 32'hC000_0000 | (lineno << 4) | w;
      end
      return l;
   endfunction

   // Clears the model the way a reset clears the cache; memory keeps its contents
   task automatic modelReset();
      for (int s = 0; s < SETS; s++) begin
         mdl_valid[s] = 1'b0;
         mdl_dirty[s] = 1'b0;
      end
      mdl_hits   = 0;
      mdl_misses = 0;
   endtask

   // Issues one request, plays physical memory with responses on the lat-th cycle,
   // checks the transaction against the model, and updates the model afterwards
   task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input int lat,
                                output int latency, output logic [31:0] rdata);
      int           set;
      int           tag;
      int           lineno;
      int           w;
      bit           exp_miss;
      bit           exp_wb;
      int           exp_lat;
      logic [255:0] victim;
      logic [31:0]  victim_addr;
      int           cyc;
      int           wb_cnt;
      int           fill_cnt;
      bit           both_seen;
      bit           timed_out;
      bit           done;
      set         = int'((addr >> 5) % SETS);
      tag         = int'(addr >> (5 + S_INDEX));
      lineno      = int'(addr >> 5);
      w           = int'(addr[4:2]);
      exp_miss    = !(mdl_valid[set] && (mdl_tag[set] == tag));
      exp_wb      = exp_miss && mdl_dirty[set];
      exp_lat     = exp_miss ? (exp_wb ? 1 + 2*lat : 1 + lat) : 0;
      victim      = mdl_line[set];
      victim_addr = 32'((mdl_tag[set] << (5 + S_INDEX)) | (set << 5));
      cyc         = 0;
      wb_cnt      = 0;
      fill_cnt    = 0;
      both_seen   = 1'b0;
      timed_out   = 1'b0;
      done        = 1'b0;
      latency     = -1;
      rdata       = '0;

      d_read          = rd;
      d_write         = wr;
      d_addr          = addr;
      mem_byte_enable = be;
      d_wdata         = wd;

      while (!done) begin
         @(negedge clk);
         if (pmem_read && pmem_write) both_seen = 1'b1;
         if (d_resp) begin
            latency = cyc;
            rdata   = d_rdata;
            done    = 1'b1;
         end else if (pmem_write) begin
            wb_cnt++;
            if (wb_cnt == 1) begin
               checkOutput("wb_addr", pmem_addr, victim_addr);
               checkOutput("wb_data", pmem_wdata, victim);
            end
            if (wb_cnt == lat) pmem_resp = 1'b1;
         end else if (pmem_read) begin
            fill_cnt++;
            if (fill_cnt == 1) checkOutput("fill_addr", pmem_addr, {addr[31:5], 5'b0});
            if (fill_cnt == lat) begin
               pmem_rdata = mem_line(lineno);
               pmem_resp  = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         pmem_resp = 1'b0;
         cyc++;
         if (!done && cyc > 100) begin
            timed_out = 1'b1;
            done      = 1'b1;
         end
      end
      d_read          = 1'b0;
      d_write         = 1'b0;
      mem_byte_enable = '0;

      checkOutput("resp_timeout", timed_out, 1'b0);
      checkOutput("latency", latency, exp_lat);
      checkOutput("writeback_seen", (wb_cnt > 0), exp_wb);
      checkOutput("fill_seen", (fill_cnt > 0), exp_miss);
      checkOutput("pmem_rd_wr_both", both_seen, 1'b0);

      if (exp_miss) begin
         if (exp_wb) backing[int'(victim_addr >> 5)] = victim;
         mdl_line[set]  = mem_line(lineno);
         mdl_valid[set] = 1'b1;
         mdl_dirty[set] = 1'b0;
         mdl_tag[set]   = tag;
         mdl_misses++;
      end
      mdl_hits++;
      if (wr) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mdl_line[set][w*32 + 8*b +: 8] = wd[8*b +: 8];
         end
         if (be != 4'b0) mdl_dirty[set] = 1'b1;
      end else begin
         checkOutput("load_data", rdata, mdl_line[set][w*32 +: 32]);
      end
   endtask

   initial begin
      int           lat_seen;
      logic [31:0]  data_seen;
      logic [255:0] l;
      bit           found;

      modelReset();
      for (int w = 0; w < 8; w++) begin
         l[w*32 +: 32] = 32'hA000_0000 + w;
      end
      l[2*32 +: 32] = 32'hDEAD_BEEF;
      backing[2] = l;
      for (int w = 0; w < 8; w++) begin
         l[w*32 +: 32] = 32'hB000_0000 + w;
      end
      backing[10] = l;

      vecs[0] = '{1, 0, 32'h40,  4'h0, 32'h0,        3, 1, 32'hA000_0000, 4};
      vecs[1] = '{1, 0, 32'h48,  4'h0, 32'h0,        1, 1, 32'hDEAD_BEEF, 0};
      vecs[2] = '{0, 1, 32'h48,  4'h5, 32'h1122_3344, 1, 0, 32'h0,         0};
      vecs[3] = '{1, 0, 32'h48,  4'h0, 32'h0,        1, 1, 32'hDE22_BE44, 0};
      vecs[4] = '{1, 0, 32'h144, 4'h0, 32'h0,        2, 1, 32'hB000_0001, 5};
      vecs[5] = '{1, 0, 32'h48,  4'h0, 32'h0,        1, 1, 32'hDE22_BE44, 2};
      vecs[6] = '{0, 1, 32'h4C,  4'h0, 32'hFFFF_FFFF, 1, 0, 32'h0,         0};
      vecs[7] = '{1, 0, 32'h140, 4'h0, 32'h0,        1, 1, 32'hB000_0000, 2};
      vecs[8] = '{1, 1, 32'h140, 4'hF, 32'h1234_5678, 1, 0, 32'h0,         0};
      vecs[9] = '{1, 0, 32'h140, 4'h0, 32'h0,        1, 1, 32'h1234_5678, 0};

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ctrl", {d_resp, pmem_read, pmem_write}, 3'b000);
      checkOutput("rst_d_rdata", d_rdata, 32'h0);
      checkOutput("rst_pmem_addr", pmem_addr, 32'h0);
      checkOutput("rst_pmem_wdata", pmem_wdata, 256'h0);
      checkOutput("rst_hit_count", hit_count, 32'h0);
      checkOutput("rst_miss_count", miss_count, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd,
                       vecs[i].lat, lat_seen, data_seen);
         checkOutput($sformatf("vec%0d_latency", i), lat_seen, vecs[i].exp_lat);
         if (vecs[i].chk_data) checkOutput($sformatf("vec%0d_rdata", i), data_seen, vecs[i].exp_data);
      end

      // Idle with resident lines: outputs stay quiet
      @(negedge clk);
      checkOutput("idle_d_resp", d_resp, 1'b0);
      checkOutput("idle_d_rdata", d_rdata, 32'h0);
      checkOutput("idle_pmem_addr", pmem_addr, 32'h0);
      checkOutput("idle_pmem_wdata", pmem_wdata, 256'h0);
      @(posedge clk);
      #1;

      // Reset during FILL, then a stray pmem_resp in IDLE
      d_read = 1'b1;
      d_addr = 32'h200;
      found  = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (pmem_read) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput("midfill_pmem_read_seen", found, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("midfill_pmem_read_drop", pmem_read, 1'b0);
      checkOutput("midfill_pmem_addr", pmem_addr, 32'h0);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      d_read     = 1'b0;
      pmem_rdata = {8{$urandom}};
      pmem_resp  = 1'b1;
      @(negedge clk);
      checkOutput("stray_resp_pmem_read", pmem_read, 1'b0);
      checkOutput("stray_resp_d_resp", d_resp, 1'b0);
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      modelReset();

      applyStimulus(1, 0, 32'h200, 4'h0, 32'h0, 2, lat_seen, data_seen);
      checkOutput("after_reset_remiss_latency", lat_seen, 3);
      applyStimulus(1, 0, 32'h204, 4'h0, 32'h0, 1, lat_seen, data_seen);
      applyStimulus(1, 0, 32'h208, 4'h0, 32'h0, 1, lat_seen, data_seen);
      applyStimulus(1, 0, 32'h20C, 4'h0, 32'h0, 1, lat_seen, data_seen);
`ifdef DCACHE_PERF_EN
      checkOutput("perf_hit_count", hit_count, 32'd4);
      checkOutput("perf_miss_count", miss_count, 32'd1);
`else
      checkOutput("perf_hit_count_off", hit_count, 32'd0);
      checkOutput("perf_miss_count_off", miss_count, 32'd0);
`endif

      // Random traffic over a few tags per set to force hits, clean and dirty evictions
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         bit          r;
         bit          wbit;
         a    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         r    = $urandom_range(0, 1);
         wbit = $urandom_range(0, 1);
         if (!r && !wbit) r = 1'b1;
         applyStimulus(r, wbit, a, 4'($urandom), $urandom, $urandom_range(1, 3),
                       lat_seen, data_seen);
      end

`ifdef DCACHE_PERF_EN
      checkOutput("final_hit_count", hit_count, mdl_hits);
      checkOutput("final_miss_count", miss_count, mdl_misses);
`else
      checkOutput("final_hit_count_off", hit_count, 32'd0);
      checkOutput("final_miss_count_off", miss_count, 32'd0);
`endif

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
